// File: rtl/seq_multiplier_param.sv
// Shift-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH, fixed latency.
// Signed operands are multiplied as magnitudes; the sign is applied at completion.
module seq_multiplier_param #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic               sgn;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;
    logic               last;

    // With SIGNED_EN=0 sgn is constant 0 and the sign logic folds away.
    always_comb begin
        sgn      = (SIGNED_EN != 1'b0) ? is_signed : 1'b0;
        a_mag    = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag    = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        acc_next = {sum, acc[WIDTH-1:1]};
        last     = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a_mag;
                        acc   <= {{WIDTH{1'b0}}, b_mag};
                        neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        product <= neg ? -acc_next : acc_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed-vector and random bench for seq_multiplier_param (8-bit signed
// instance plus a 16-bit unsigned-only instance).
module tb_seq_multiplier_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    logic        start2;
    logic        is_signed2;
    logic [15:0] a2;
    logic [15:0] b2;
    logic        busy2;
    logic        done2;
    logic [31:0] product2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_multiplier_param #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    seq_multiplier_param #(.WIDTH(16), .SIGNED_EN(1'b0)) dut16 (
        .clk(clk), .reset(reset), .start(start2), .is_signed(is_signed2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .product(product2)
    );

    typedef struct {
        string      name;
        logic       sg;
        logic [7:0] x;
        logic [7:0] y;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Accept one op, then watch it until done; reports latency, busy
    // count, product-hold violations and the final product.
    task automatic do_op(input logic sg, input logic [7:0] x,
                         input logic [7:0] y, output int lat,
                         output int bcnt, output int holdbad,
                         output logic [15:0] p);
        logic [15:0] prev;
        prev = product;
        @(negedge clk);
        start = 1'b1;
        is_signed = sg;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = ~x;
        b = ~y;
        is_signed = ~sg;
        lat = 0;
        bcnt = 0;
        holdbad = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            if (product !== prev) holdbad++;
            @(negedge clk);
            lat++;
        end
        p = product;
    endtask

    task automatic do_op16(input logic [15:0] x, input logic [15:0] y,
                           output int lat, output logic [31:0] p);
        @(negedge clk);
        start2 = 1'b1;
        is_signed2 = 1'($urandom_range(0, 1));
        a2 = x;
        b2 = y;
        @(negedge clk);
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        p = product2;
    endtask

    function automatic logic [15:0] ref_mul(input logic sg,
                                            input logic [7:0] x,
                                            input logic [7:0] y);
        logic [15:0] xe;
        logic [15:0] ye;
        xe = sg ? {{8{x[7]}}, x} : {8'h00, x};
        ye = sg ? {{8{y[7]}}, y} : {8'h00, y};
        return 16'(xe * ye);
    endfunction

    initial begin
        int lat;
        int bcnt;
        int holdbad;
        int rand_bad;
        logic [15:0] p;
        logic [15:0] held;
        logic [31:0] p32;
        logic [7:0] rx;
        logic [7:0] ry;
        logic rs;
        logic [15:0] rx16;
        logic [15:0] ry16;

        vecs[0]  = '{"u5x3",     1'b0, 8'd5,   8'd3,   16'd15};
        vecs[1]  = '{"u255x255", 1'b0, 8'd255, 8'd255, 16'hFE01};
        vecs[2]  = '{"u10x20",   1'b0, 8'd10,  8'd20,  16'd200};
        vecs[3]  = '{"u15x15",   1'b0, 8'd15,  8'd15,  16'd225};
        vecs[4]  = '{"s-5x3",    1'b1, 8'hFB,  8'h03,  16'hFFF1};
        vecs[5]  = '{"s-128x-128", 1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[6]  = '{"s-128x127", 1'b1, 8'h80, 8'h7F,  16'hC080};
        vecs[7]  = '{"s0x-1",    1'b1, 8'h00,  8'hFF,  16'h0000};
        vecs[8]  = '{"u80x80",   1'b0, 8'h80,  8'h80,  16'h4000};
        vecs[9]  = '{"s-1x-1",   1'b1, 8'hFF,  8'hFF,  16'h0001};
        vecs[10] = '{"u0x0",     1'b0, 8'h00,  8'h00,  16'h0000};

        reset = 1'b0;
        start = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        start2 = 1'b0;
        is_signed2 = 1'b0;
        a2 = '0;
        b2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_product16", product2, 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].sg, vecs[i].x, vecs[i].y, lat, bcnt, holdbad, p);
            chk({vecs[i].name, "_product"}, 32'(p), 32'(vecs[i].exp));
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'd8);
            chk({vecs[i].name, "_busycycles"}, 32'(bcnt), 32'd8);
            chk({vecs[i].name, "_hold"}, 32'(holdbad), 32'd0);
            @(negedge clk);
            chk({vecs[i].name, "_donewidth"}, 32'(done), 32'd0);
            chk({vecs[i].name, "_idlebusy"}, 32'(busy), 32'd0);
        end

        // start re-pulsed while busy must be ignored
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 8'd12; b = 8'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'd99; b = 8'd77;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("ignore_latency", 32'(lat), 32'd8);
        chk("ignore_product", 32'(product), 32'd132);
        @(negedge clk);
        chk("ignore_no_second_op", 32'(busy), 32'd0);

        // back-to-back: start in the done cycle
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; a = 8'hF9; b = 8'd6;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_product", 32'(product), 32'hFFD6);
        start = 1'b1; is_signed = 1'b0; a = 8'd200; b = 8'd3;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept_busy", 32'(busy), 32'd1);
        chk("b2b_done_cleared", 32'(done), 32'd0);
        held = product;
        lat = 0;
        while (!done && lat < 20) begin
            if (product !== held) lat = 100;
            @(negedge clk);
            lat++;
        end
        chk("b2b_second_latency", 32'(lat), 32'd8);
        chk("b2b_second_product", 32'(product), 32'd600);
        held = product;
        repeat (5) @(negedge clk);
        chk("hold_idle", 32'(product), 32'(held));

        // reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 8'd50; b = 8'd40;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_product", 32'(product), 32'd0);
        lat = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) lat++;
        end
        chk("midrst_no_done", 32'(lat), 32'd0);
        do_op(1'b0, 8'd7, 8'd9, lat, bcnt, holdbad, p);
        chk("midrst_fresh_product", 32'(p), 32'd63);
        chk("midrst_fresh_latency", 32'(lat), 32'd8);

        // random, mixed signedness
        rand_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            do_op(rs, rx, ry, lat, bcnt, holdbad, p);
            if (p !== ref_mul(rs, rx, ry) || lat != 8) begin
                rand_bad++;
                if (rand_bad <= 5)
                    chk("rand8_product", 32'(p), 32'(ref_mul(rs, rx, ry)));
            end
        end
        chk("rand8_bad_count", 32'(rand_bad), 32'd0);

        // 16-bit, is_signed ignored
        do_op16(16'hFFFF, 16'hFFFF, lat, p32);
        chk("w16_max_product", p32, 32'hFFFE0001);
        chk("w16_latency", 32'(lat), 32'd16);
        do_op16(16'h8000, 16'h0002, lat, p32);
        chk("w16_unsigned_msb", p32, 32'h00010000);
        rand_bad = 0;
        for (int i = 0; i < 150; i++) begin
            rx16 = 16'($urandom);
            ry16 = 16'($urandom);
            do_op16(rx16, ry16, lat, p32);
            if (p32 !== {16'h0, rx16} * {16'h0, ry16} || lat != 16) begin
                rand_bad++;
                if (rand_bad <= 5)
                    chk("rand16_product", p32, {16'h0, rx16} * {16'h0, ry16});
            end
        end
        chk("rand16_bad_count", 32'(rand_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
